axis_sync_register_bank: RTL

- Downstream consumer of the AXI-stream constant/parameter sources.
- Accepts beats carrying {data, dest} and stages each beat into a shadow register selected by dest.
- On the next sync pulse, copies all pending shadow entries into the active bank in one cycle, so control-loop parameters change coherently at the sampling instant.
- Active bank drives parameter inputs of downstream datapath blocks (controllers, modulators).

---
 rtl/axis_sync_register_bank_pkg.sv | 16 +
 rtl/sync_shadow_slot.sv | 51 +++++
 rtl/axis_sync_register_bank.sv | 102 ++++++++++
 3 files changed

// File: rtl/axis_sync_register_bank_pkg.sv
// Shared types for the sync register bank: dest width, index sizing helper, per-entry status.
package axis_sync_register_bank_pkg;

  localparam int DEST_W = 32;

  // Never returns 0, so a single-entry bank still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } upd_state_t;

endpackage

// File: rtl/sync_shadow_slot.sv
// One bank entry: shadow/active pair plus pending flag; commit copies shadow to active one cycle after sync.
// A set in the same cycle as a commit re-arms pending with the new shadow data.
module sync_shadow_slot
  import axis_sync_register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set,
  input  logic [DATA_WIDTH-1:0] set_data,
  input  logic                  commit,
  output logic [DATA_WIDTH-1:0] active,
  output upd_state_t            state
);

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  upd_state_t            state_q, state_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;
    if (commit && (state_q == STAGED)) begin
      active_d = shadow_q;
      state_d  = IDLE;
    end
    // The commit above has already taken the old shadow; the new beat waits for the next sync.
    if (set) begin
      shadow_d = set_data;
      state_d  = STAGED;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
      state_q  <= IDLE;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      state_q  <= state_d;
    end
  end

  assign active = active_q;
  assign state  = state_q;

endmodule

// File: rtl/axis_sync_register_bank.sv
// Stages stream beats per dest into shadow slots and commits all pending slots on sync (values valid sync+1).
// AXIS_SYNC_REGISTER_BANK_BACKPRESSURE_EN: stall beats aimed at a still-pending slot; otherwise last write wins.
module axis_sync_register_bank
  import axis_sync_register_bank_pkg::*;
#(
  parameter int          N_REGISTERS = 8,
  parameter int          DATA_WIDTH  = 64,
  parameter logic [31:0] DEST_BASE   = 32'd0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   sync,
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  input  logic [DATA_WIDTH-1:0]                  data_in_data,
  input  logic [DEST_W-1:0]                      data_in_dest,
  output logic [N_REGISTERS-1:0][DATA_WIDTH-1:0] values,
  output logic                                   update_strobe,
  output logic [N_REGISTERS-1:0]                 updated_mask,
  output logic                                   dest_error
);

  localparam int IDX_W = idx_width(N_REGISTERS);
  typedef logic [IDX_W-1:0] idx_t;

  logic [DEST_W-1:0]      idx_full;
  logic                   in_range;
  idx_t                   idx;
  logic                   handshake;
  logic [N_REGISTERS-1:0] pending;
  logic [N_REGISTERS-1:0] set_vec;
  upd_state_t             slot_state [N_REGISTERS];

  logic                   ready_q, ready_d;
  logic                   strobe_q, strobe_d;
  logic [N_REGISTERS-1:0] mask_q, mask_d;
  logic                   err_q, err_d;

  // Unsigned wrap makes dests below DEST_BASE land far out of range.
  assign idx_full  = data_in_dest - DEST_BASE;
  assign in_range  = idx_full < DEST_W'(N_REGISTERS);
  assign idx       = idx_t'(idx_full);

`ifdef AXIS_SYNC_REGISTER_BANK_BACKPRESSURE_EN
  assign data_in_ready = ready_q & ~(data_in_valid & in_range & pending[idx]);
`else
  assign data_in_ready = ready_q;
`endif

  assign handshake = data_in_valid & data_in_ready;

  always_comb begin
    set_vec = '0;
    if (handshake && in_range) begin
      set_vec[idx] = 1'b1;
    end
  end

  for (genvar i = 0; i < N_REGISTERS; i++) begin : g_slot
    sync_shadow_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .set      (set_vec[i]),
      .set_data (data_in_data),
      .commit   (sync),
      .active   (values[i]),
      .state    (slot_state[i])
    );
    assign pending[i] = (slot_state[i] == STAGED);
  end

  always_comb begin
    ready_d  = 1'b1;
    strobe_d = sync & (|pending);
    mask_d   = mask_q;
    err_d    = err_q | (handshake & ~in_range);
    if (sync && (|pending)) begin
      mask_d = pending;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
    end
  end

  assign update_strobe = strobe_q;
  assign updated_mask  = mask_q;
  assign dest_error    = err_q;

endmodule
